// File: rtl/i8088_bus_pkg.sv
// Shared definitions for the 8088-to-AXI4-Lite bridge.
//   - FSM state encodings (legacy localparam constants).
//   - Offsets of the three local I/O ports relative to LOCAL_IO.
//   - Byte-lane helpers mapping the 8-bit CPU bus onto a 32-bit AXI word.
package i8088_bus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_AR   = 3'd1;
  localparam state_t ST_RD_R    = 3'd2;
  localparam state_t ST_RD_HOLD = 3'd3;
  localparam state_t ST_WR_REQ  = 3'd4;
  localparam state_t ST_WR_B    = 3'd5;
  localparam state_t ST_WR_HOLD = 3'd6;

  localparam logic [1:0] LOCAL_OFS_LED  = 2'd0;
  localparam logic [1:0] LOCAL_OFS_GPIO = 2'd1;
  localparam logic [1:0] LOCAL_OFS_BTN  = 2'd2;
  localparam logic [15:0] LOCAL_PORT_COUNT = 16'd3;

  // Write strobe selecting the single byte lane addressed by A[1:0].
  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Byte extracted from an AXI read word for the addressed lane.
  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [1:0]  lane);
    return word[8*lane +: 8];
  endfunction

  // CPU byte replicated onto all four lanes; wstrb picks the live one.
  function automatic logic [31:0] byte_rep(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/i8088_bus_bridge_local_io.sv
// Local I/O block: LED and GPIO registers plus the push-button input port.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_wr_en        : one-cycle write pulse for the selected port
//   i_sel          : port offset (LED, GPIO, buttons)
//   i_wdata        : CPU write byte
//   i_buttons      : raw push-button levels
//   o_led, o_gpio  : register outputs
//   o_rdata        : combinational read data for the selected port
module i8088_local_io
  import i8088_bus_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [1:0] i_sel,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_buttons,
  output logic [3:0] o_led,
  output logic [4:0] o_gpio,
  output logic [7:0] o_rdata
);

  logic [3:0] r_led;
  logic [4:0] r_gpio;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_led  <= '0;
      r_gpio <= '0;
    end else if (i_wr_en) begin
      case (i_sel)
        LOCAL_OFS_LED:  r_led  <= i_wdata[3:0];
        LOCAL_OFS_GPIO: r_gpio <= i_wdata[4:0];
        default: ;  // button port is read-only
      endcase
    end
  end

  // NOTE: o_rdata gets a default before the case so no latch is inferred
  // for unlisted selects.
  always_comb begin
    o_rdata = '0;
    case (i_sel)
      LOCAL_OFS_LED:  o_rdata = {4'b0, r_led};
      LOCAL_OFS_GPIO: o_rdata = {3'b0, r_gpio};
      LOCAL_OFS_BTN:  o_rdata = {4'b0, i_buttons};
      default:        o_rdata = '0;
    endcase
  end

  assign o_led  = r_led;
  assign o_gpio = r_gpio;

endmodule

// File: rtl/i8088_bus_bridge.sv
// 8088 minimum-mode bus to single-beat AXI4-Lite master bridge.
// Memory cycles map to MEM_BASE, I/O cycles to IO_BASE, except three local
// ports at LOCAL_IO..LOCAL_IO+2 (LED, GPIO, buttons) handled without waits.
// READY_cpu is held low from ALE until the AXI transaction completes.
// Ports:
//   AXI_CLK / CPU_RESET         : sole clock, synchronous active-high reset
//   A_cpu, AD8_in_cpu, strobes  : pre-registered CPU bus inputs
//   AD8_out_cpu, AD8_enout_cpu  : read data and pad enable toward the CPU
//   dbus_DIR, READY_cpu         : transceiver direction, wait-state control
//   INTR_cpu, NMI_cpu           : tied low
//   LED, GPIO, PUSH_BUTTON      : local I/O
//   AXI_*                       : AXI4-Lite master (AR, R, AW, W, B)
module i8088_bus_bridge
  import i8088_bus_pkg::*;
#(
  parameter logic [32:0] MEM_BASE = 33'h0_8000_0000,
  parameter logic [32:0] IO_BASE  = 33'h0_4000_0000,
  parameter logic [15:0] LOCAL_IO = 16'h0080
) (
  input  logic        AXI_CLK,
  input  logic        CPU_RESET,
  input  logic [19:0] A_cpu,
  input  logic [7:0]  AD8_in_cpu,
  input  logic        nRD_cpu,
  input  logic        nWR_cpu,
  input  logic        IO_nM_cpu,
  input  logic        ALE_cpu,
  output logic [7:0]  AD8_out_cpu,
  output logic        AD8_enout_cpu,
  output logic        dbus_DIR,
  output logic        READY_cpu,
  output logic        INTR_cpu,
  output logic        NMI_cpu,
  output logic [3:0]  LED,
  output logic [4:0]  GPIO,
  input  logic [3:0]  PUSH_BUTTON,
  output logic [32:0] AXI_araddr33,
  output logic [2:0]  AXI_arprot,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  input  logic [31:0] AXI_rdata,
  input  logic [1:0]  AXI_rresp,
  input  logic        AXI_rvalid,
  output logic        AXI_rready,
  output logic [32:0] AXI_awaddr33,
  output logic [2:0]  AXI_awprot,
  output logic        AXI_awvalid,
  input  logic        AXI_awready,
  output logic [31:0] AXI_wdata,
  output logic [3:0]  AXI_wstrb,
  output logic        AXI_wvalid,
  input  logic        AXI_wready,
  input  logic [1:0]  AXI_bresp,
  input  logic        AXI_bvalid,
  output logic        AXI_bready
);

  state_t      r_state;
  logic        r_nrd_prev;
  logic        r_nwr_prev;
  logic        r_ale_prev;
  logic        r_ready;
  logic [32:0] r_addr;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_pend;
  logic        r_w_pend;
  logic [7:0]  r_rd_byte;
  logic        r_rd_valid;

  logic [15:0] w_io_ofs;
  logic        w_is_local;
  logic [32:0] w_axi_addr;
  logic        w_rd_fall;
  logic        w_wr_fall;
  logic        w_ale_rise;
  logic        w_local_rd;
  logic        w_local_wr;
  logic [7:0]  w_local_rdata;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_unused_bresp;

  // Offset below LOCAL_IO wraps to a large value, so one compare covers
  // both ends of the local window.
  assign w_io_ofs   = A_cpu[15:0] - LOCAL_IO;
  assign w_is_local = IO_nM_cpu && (w_io_ofs < LOCAL_PORT_COUNT);

  assign w_axi_addr = IO_nM_cpu ? IO_BASE  + {17'b0, A_cpu[15:2], 2'b00}
                                : MEM_BASE + {13'b0, A_cpu[19:2], 2'b00};

  assign w_rd_fall  = r_nrd_prev & ~nRD_cpu;
  assign w_wr_fall  = r_nwr_prev & ~nWR_cpu;
  assign w_ale_rise = ALE_cpu & ~r_ale_prev;

  assign w_local_rd = ~nRD_cpu & w_is_local;
  assign w_local_wr = w_wr_fall & w_is_local;

  // A channel counts as done if it already handshook or does so this edge.
  assign w_aw_done = ~r_aw_pend | AXI_awready;
  assign w_w_done  = ~r_w_pend  | AXI_wready;

  // Write responses are accepted without inspection.
  assign w_unused_bresp = ^AXI_bresp;

  i8088_local_io u_local_io (
    .i_clk     (AXI_CLK),
    .i_rst     (CPU_RESET),
    .i_wr_en   (w_local_wr),
    .i_sel     (w_io_ofs[1:0]),
    .i_wdata   (AD8_in_cpu),
    .i_buttons (PUSH_BUTTON),
    .o_led     (LED),
    .o_gpio    (GPIO),
    .o_rdata   (w_local_rdata)
  );

  // NOTE: every control register is reset so an interrupted transaction
  // leaves no valid asserted and no stale read data on the pads.
  always_ff @(posedge AXI_CLK) begin
    if (CPU_RESET) begin
      r_state    <= ST_IDLE;
      r_nrd_prev <= 1'b1;
      r_nwr_prev <= 1'b1;
      r_ale_prev <= 1'b0;
      r_ready    <= 1'b1;
      r_addr     <= '0;
      r_lane     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_aw_pend  <= 1'b0;
      r_w_pend   <= 1'b0;
      r_rd_byte  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_nrd_prev <= nRD_cpu;
      r_nwr_prev <= nWR_cpu;
      r_ale_prev <= ALE_cpu;

      // Wait states start as soon as an AXI-bound cycle is announced.
      if (w_ale_rise && !w_is_local) begin
        r_ready <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_rd_valid <= 1'b0;
          if (w_rd_fall && !w_is_local) begin
            r_addr  <= w_axi_addr;
            r_lane  <= A_cpu[1:0];
            r_state <= ST_RD_AR;
          end else if (w_wr_fall && !w_is_local) begin
            r_addr    <= w_axi_addr;
            r_lane    <= A_cpu[1:0];
            r_wdata   <= byte_rep(AD8_in_cpu);
            r_wstrb   <= lane_strb(A_cpu[1:0]);
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
            r_state   <= ST_WR_REQ;
          end
        end

        ST_RD_AR: begin
          if (AXI_arready) begin
            r_state <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          if (AXI_rvalid) begin
            r_rd_byte  <= (AXI_rresp != 2'b00) ? 8'hFF
                                               : lane_byte(AXI_rdata, r_lane);
            r_rd_valid <= 1'b1;
            r_ready    <= 1'b1;
            r_state    <= ST_RD_HOLD;
          end
        end

        ST_RD_HOLD: begin
          if (nRD_cpu) begin
            r_rd_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_WR_REQ: begin
          if (AXI_awready) r_aw_pend <= 1'b0;
          if (AXI_wready)  r_w_pend  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_state <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          if (AXI_bvalid) begin
            r_ready <= 1'b1;
            r_state <= ST_WR_HOLD;
          end
        end

        ST_WR_HOLD: begin
          if (nWR_cpu) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign AXI_araddr33 = r_addr;
  assign AXI_arprot   = 3'b000;
  assign AXI_arvalid  = (r_state == ST_RD_AR);
  assign AXI_rready   = (r_state == ST_RD_R);

  assign AXI_awaddr33 = r_addr;
  assign AXI_awprot   = 3'b000;
  assign AXI_awvalid  = (r_state == ST_WR_REQ) && r_aw_pend;
  assign AXI_wdata    = r_wdata;
  assign AXI_wstrb    = r_wstrb;
  assign AXI_wvalid   = (r_state == ST_WR_REQ) && r_w_pend;
  assign AXI_bready   = (r_state == ST_WR_B);

  assign AD8_out_cpu   = w_local_rd ? w_local_rdata : r_rd_byte;
  assign AD8_enout_cpu = ~nRD_cpu & (r_rd_valid | w_local_rd);
  assign dbus_DIR      = ~nRD_cpu;
  assign READY_cpu     = r_ready;
  assign INTR_cpu      = 1'b0;
  assign NMI_cpu       = 1'b0;

endmodule

// File: tb/tb_i8088_bus_bridge.sv
// Directed self-checking bench for i8088_bus_bridge.
module tb_i8088_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] a;
  logic [7:0]  ad_in;
  logic        n_rd, n_wr, io_nm, ale;
  logic [7:0]  ad_out;
  logic        ad_en, dir, ready, intr, nmi;
  logic [3:0]  led;
  logic [4:0]  gpio;
  logic [3:0]  btn;
  logic [32:0] araddr, awaddr;
  logic [2:0]  arprot, awprot;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  i8088_bus_bridge dut (
    .AXI_CLK(clk), .CPU_RESET(rst), .A_cpu(a), .AD8_in_cpu(ad_in),
    .nRD_cpu(n_rd), .nWR_cpu(n_wr), .IO_nM_cpu(io_nm), .ALE_cpu(ale),
    .AD8_out_cpu(ad_out), .AD8_enout_cpu(ad_en), .dbus_DIR(dir),
    .READY_cpu(ready), .INTR_cpu(intr), .NMI_cpu(nmi),
    .LED(led), .GPIO(gpio), .PUSH_BUTTON(btn),
    .AXI_araddr33(araddr), .AXI_arprot(arprot), .AXI_arvalid(arvalid),
    .AXI_arready(arready), .AXI_rdata(rdata), .AXI_rresp(rresp),
    .AXI_rvalid(rvalid), .AXI_rready(rready),
    .AXI_awaddr33(awaddr), .AXI_awprot(awprot), .AXI_awvalid(awvalid),
    .AXI_awready(awready), .AXI_wdata(wdata), .AXI_wstrb(wstrb),
    .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a = '0; ad_in = '0; n_rd = 1'b1; n_wr = 1'b1; io_nm = 1'b0;
    ale = 1'b0; btn = '0; arready = 0; rdata = '0; rresp = '0; rvalid = 0;
    awready = 0; wready = 0; bresp = '0; bvalid = 0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_ready",   ready,   1);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid",  wvalid,  0);
    check("rst_rready",  rready,  0);
    check("rst_bready",  bready,  0);
    check("rst_enout",   ad_en,   0);
    check("rst_adout",   ad_out,  0);
    check("rst_led",     led,     0);
    check("rst_gpio",    gpio,    0);
    check("rst_intr_nmi", {intr, nmi}, 0);

    // Memory read at 0x12345, lane 1
    a = 20'h12345; io_nm = 1'b0; ale = 1'b1;
    step();
    check("mrd_ready_low", ready, 0);
    ale = 1'b0; n_rd = 1'b0;
    step();
    check("mrd_arvalid", arvalid, 1);
    check("mrd_araddr",  araddr,  33'h0_8001_2344);
    check("mrd_arprot",  arprot,  0);
    check("mrd_dir",     dir,     1);
    check("mrd_en_wait", ad_en,   0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("mrd_ar_drop", arvalid, 0);
    check("mrd_rready",  rready,  1);
    step();
    check("mrd_ready_wait", ready, 0);
    rdata = 32'hAABBCCDD; rresp = 2'b00; rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    check("mrd_data",     ad_out, 8'hCC);
    check("mrd_enout",    ad_en,  1);
    check("mrd_ready_hi", ready,  1);
    check("mrd_rr_drop",  rready, 0);
    n_rd = 1'b1;
    step();
    check("mrd_en_off", ad_en, 0);
    check("mrd_dir_off", dir, 0);

    // Memory write 0x5A to 0x00003, lane 3
    a = 20'h00003; io_nm = 1'b0; ale = 1'b1;
    step();
    check("mwr_ready_low", ready, 0);
    ale = 1'b0; ad_in = 8'h5A; n_wr = 1'b0;
    step();
    check("mwr_aw_w_valid", {awvalid, wvalid}, 2'b11);
    check("mwr_awaddr", awaddr, 33'h0_8000_0000);
    check("mwr_wstrb",  wstrb,  4'b1000);
    check("mwr_wdata",  wdata,  32'h5A5A5A5A);
    check("mwr_awprot", awprot, 0);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    check("mwr_valid_drop", {awvalid, wvalid}, 2'b00);
    check("mwr_bready", bready, 1);
    check("mwr_ready_wait", ready, 0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check("mwr_ready_hi", ready, 1);
    check("mwr_bready_off", bready, 0);
    n_wr = 1'b1;
    step();

    // Local LED write 0x0F to port 0x0080
    a = 20'h00080; io_nm = 1'b1; ale = 1'b1;
    step();
    check("led_ready_stays", ready, 1);
    ale = 1'b0; ad_in = 8'h0F; n_wr = 1'b0;
    step();
    check("led_value",  led, 4'hF);
    check("led_no_axi", {awvalid, wvalid, arvalid}, 3'b000);
    check("led_ready",  ready, 1);
    n_wr = 1'b1;
    step();

    // Local GPIO write 0xFF to 0x0081: only 5 bits exist
    a = 20'h00081; ad_in = 8'hFF; n_wr = 1'b0;
    step();
    check("gpio_value", gpio, 5'h1F);
    n_wr = 1'b1;
    step();
    n_rd = 1'b0; #1;
    check("gpio_readback", ad_out, 8'h1F);
    n_rd = 1'b1;
    step();

    // Push-button read at 0x0082
    btn = 4'b1010; a = 20'h00082; io_nm = 1'b1; ale = 1'b1;
    step();
    ale = 1'b0; n_rd = 1'b0; #1;
    check("btn_data",  ad_out, 8'h0A);
    check("btn_enout", ad_en,  1);
    step();
    check("btn_no_ar", arvalid, 0);
    check("btn_ready", ready,   1);
    n_rd = 1'b1;
    step();

    // I/O write 0x11 to 0x03F8 with staggered ready signals
    a = 20'h003F8; io_nm = 1'b1; ale = 1'b1;
    step();
    check("iow_ready_low", ready, 0);
    ale = 1'b0; ad_in = 8'h11; n_wr = 1'b0;
    step();
    check("iow_awaddr", awaddr, 33'h0_4000_03F8);
    check("iow_wstrb",  wstrb,  4'b0001);
    check("iow_wdata",  wdata,  32'h11111111);
    step(); step();
    check("iow_both_held", {awvalid, wvalid}, 2'b11);
    awready = 1'b1;
    step();
    awready = 1'b0;
    check("iow_aw_only", {awvalid, wvalid}, 2'b01);
    check("iow_no_bready", bready, 0);
    step();
    check("iow_w_held", {awvalid, wvalid}, 2'b01);
    wready = 1'b1;
    step();
    wready = 1'b0;
    check("iow_w_drop", wvalid, 0);
    check("iow_bready", bready, 1);
    bresp = 2'b10; bvalid = 1'b1;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    check("iow_ready_hi", ready, 1);
    n_wr = 1'b1;
    step();

    // I/O read at 0x0301 with error response returns 0xFF
    a = 20'h00301; io_nm = 1'b1; ale = 1'b1;
    step();
    ale = 1'b0; n_rd = 1'b0;
    step();
    check("err_araddr", araddr, 33'h0_4000_0300);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rdata = 32'h12345678; rresp = 2'b10; rvalid = 1'b1;
    step();
    rvalid = 1'b0; rresp = 2'b00;
    check("err_data", ad_out, 8'hFF);
    n_rd = 1'b1;
    step();

    // Reset while waiting in RD_R
    a = 20'h00010; io_nm = 1'b0; ale = 1'b1;
    step();
    ale = 1'b0; n_rd = 1'b0;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("mrst_in_rd_r", rready, 1);
    rst = 1'b1;
    step();
    check("mrst_arvalid", arvalid, 0);
    check("mrst_rready",  rready,  0);
    check("mrst_ready",   ready,   1);
    check("mrst_enout",   ad_en,   0);
    check("mrst_led",     led,     0);
    rst = 1'b0; n_rd = 1'b1;
    rdata = 32'hDEADBEEF; rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    check("late_r_ready", ready,  1);
    check("late_r_rr",    rready, 0);
    check("late_r_data",  ad_out, 8'h00);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
